// File: rtl/cache_2way_ctrl.sv
// cache_2way_ctrl
//   Miss-handling controller for a 2-way set-associative cache array.
//   It accepts one CPU word load/store at a time and runs a compare lookup.
//   On a miss it inspects the victim, writes it back if dirty, refills the
//   block from memory, installs it, and then replays the original access.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   cpu_*               CPU request (req/we/addr/byte_w_en/wdata) and
//                       response (rdata/ready)
//   c_*                 2-way array controls (out) and array status (in)
//   mem_*               block memory port: req/we/addr/wdata out,
//                       rdata/ready in
//   miss_cnt, wb_cnt    wrapping miss and write-back event counters
module cache_2way_ctrl #(
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 6,
  parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [31:0]                  cpu_addr,
  input  logic [3:0]                   cpu_byte_w_en,
  input  logic [31:0]                  cpu_wdata,
  output logic [31:0]                  cpu_rdata,
  output logic                         cpu_ready,
  output logic                         c_enable,
  output logic                         c_cmp,
  output logic                         c_write,
  output logic                         c_valid_in,
  output logic [3:0]                   c_byte_w_en,
  output logic [TAG_WIDTH-1:0]         c_tag_in,
  output logic [INDEX_WIDTH-1:0]       c_index,
  output logic [OFFSET_WIDTH-1:0]      c_word_sel,
  output logic [31:0]                  c_data_in,
  output logic [32*(1<<OFFSET_WIDTH)-1:0] c_data_block_in,
  input  logic                         c_hit,
  input  logic                         c_dirty,
  input  logic                         c_valid_out,
  input  logic [TAG_WIDTH-1:0]         c_tag_out,
  input  logic [31:0]                  c_data_out,
  input  logic [32*(1<<OFFSET_WIDTH)-1:0] c_data_wb,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [32*(1<<OFFSET_WIDTH)-1:0] mem_wdata,
  input  logic [32*(1<<OFFSET_WIDTH)-1:0] mem_rdata,
  input  logic                         mem_ready,
  output logic [15:0]                  miss_cnt,
  output logic [15:0]                  wb_cnt
);

  localparam int BW  = 32 * (1 << OFFSET_WIDTH);
  localparam int LOW = OFFSET_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_VICTIM, S_WRITEBACK, S_REFILL, S_INSTALL
  } state_t;

  state_t                    state;
  logic                      req_we;
  logic [TAG_WIDTH-1:0]      req_tag;
  logic [INDEX_WIDTH-1:0]    req_index;
  logic [OFFSET_WIDTH-1:0]   req_word;
  logic [3:0]                req_be;
  logic [31:0]               req_wdata;
  logic [TAG_WIDTH-1:0]      vic_tag;
  // One block buffer serves both directions: it holds the victim block from
  // VICTIM through WRITEBACK, then is overwritten by the refill data in
  // REFILL for use in INSTALL. The two lifetimes never overlap.
  logic [BW-1:0]             blk;

  // Byte-offset bits of the CPU address carry no information for word access.
  logic                      addr_lsb_unused;
  assign addr_lsb_unused = ^cpu_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_index <= '0;
      req_word  <= '0;
      req_be    <= '0;
      req_wdata <= '0;
      vic_tag   <= '0;
      blk       <= '0;
      miss_cnt  <= '0;
      wb_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_addr[31 -: TAG_WIDTH];
            req_index <= cpu_addr[LOW +: INDEX_WIDTH];
            req_word  <= cpu_addr[2 +: OFFSET_WIDTH];
            req_be    <= cpu_byte_w_en;
            req_wdata <= cpu_wdata;
            state     <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (c_hit) begin
            state <= S_IDLE;
          end else begin
            miss_cnt <= miss_cnt + 16'd1;
            state    <= S_VICTIM;
          end
        end
        S_VICTIM: begin
          vic_tag <= c_tag_out;
          blk     <= c_data_wb;
          if (c_valid_out && c_dirty) begin
            wb_cnt <= wb_cnt + 16'd1;
            state  <= S_WRITEBACK;
          end else begin
            state <= S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) state <= S_REFILL;
        end
        S_REFILL: begin
          if (mem_ready) begin
            blk   <= mem_rdata;
            state <= S_INSTALL;
          end
        end
        S_INSTALL: state <= S_COMPARE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_rdata       = '0;
    cpu_ready       = 1'b0;
    c_enable        = 1'b0;
    c_cmp           = 1'b0;
    c_write         = 1'b0;
    c_valid_in      = 1'b0;
    c_byte_w_en     = '0;
    c_tag_in        = '0;
    c_index         = '0;
    c_word_sel      = '0;
    c_data_in       = '0;
    c_data_block_in = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    // The index stays on the array for the whole miss sequence so the way
    // picked as victim is the same way that gets installed.
    if (state != S_IDLE) begin
      c_tag_in   = req_tag;
      c_index    = req_index;
      c_word_sel = req_word;
    end
    case (state)
      S_COMPARE: begin
        c_enable    = 1'b1;
        c_cmp       = 1'b1;
        c_valid_in  = 1'b1;
        c_write     = req_we;
        c_byte_w_en = req_be;
        c_data_in   = req_wdata;
        cpu_ready   = c_hit;
        if (c_hit && !req_we) cpu_rdata = c_data_out;
      end
      S_VICTIM: begin
        c_enable = 1'b1;
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_tag, req_index, {LOW{1'b0}}};
        mem_wdata = blk;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, {LOW{1'b0}}};
      end
      S_INSTALL: begin
        c_enable        = 1'b1;
        c_write         = 1'b1;
        c_valid_in      = 1'b1;
        c_data_block_in = blk;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cache_2way_ctrl.md
# cache_2way_ctrl

Miss-handling controller that drives the 2-way set-associative cache array from the CPU side and the block memory side. Accepts one CPU word load/store at a time, runs the compare/lookup on the array, and on a miss performs victim inspection, dirty write-back, block refill and install before replaying the access. Sits between the CPU memory stage and the memory port, instantiated next to the 2-way array.

## Interface
- OFFSET_WIDTH, 3, log2 words per block
- INDEX_WIDTH, 6, log2 sets
- TAG_WIDTH, 30-OFFSET_WIDTH-INDEX_WIDTH, tag bits
- BW = 32*(1<<OFFSET_WIDTH), block width (localparam)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- cpu_req  in  1  request valid; held with stable fields until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; [1:0] ignored
- cpu_byte_w_en  in  4  store byte enables
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid when cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- c_enable, c_cmp, c_write, c_valid_in  out  1 each  array controls
- c_byte_w_en  out  4;  c_tag_in  out  TAG_WIDTH;  c_index  out  INDEX_WIDTH;  c_word_sel  out  OFFSET_WIDTH
- c_data_in  out  32;  c_data_block_in  out  BW
- c_hit, c_dirty, c_valid_out  in  1 each;  c_tag_out  in  TAG_WIDTH;  c_data_out  in  32;  c_data_wb  in  BW
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = block write-back, 0 = block read
- mem_addr  out  32  block-aligned byte address (low OFFSET_WIDTH+2 bits zero)
- mem_wdata  out  BW;  mem_rdata  in  BW;  mem_ready  in  1 (one-cycle pulse)
- miss_cnt, wb_cnt  out  16 each  wrapping event counters

## Operation
- Address split (latched at accept): tag = addr[31:32-TAG_WIDTH], index next INDEX_WIDTH bits, word_sel = addr[OFFSET_WIDTH+1:2].
- States: IDLE, COMPARE, VICTIM, WRITEBACK, REFILL, INSTALL.
- IDLE: array idle (all c_* zero). cpu_req=1 -> latch we/addr/byte_w_en/wdata, go COMPARE.
- COMPARE: c_enable=1, c_cmp=1, c_valid_in=1, c_write=latched we, latched tag/index/word_sel/data/byte enables. c_hit=1 -> cpu_ready=1, cpu_rdata=c_data_out (loads; 0 for stores), go IDLE; store merges in array same cycle and marks line dirty. c_hit=0 -> miss_cnt+1, go VICTIM.
- VICTIM: c_enable=1, c_cmp=0, c_write=0, same index. Latch c_tag_out and c_data_wb. c_valid_out & c_dirty -> WRITEBACK, wb_cnt+1; else REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, zeros}, mem_wdata=latched block. mem_ready -> REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={req tag, index, zeros}. mem_ready -> latch mem_rdata, go INSTALL.
- INSTALL: c_enable=1, c_cmp=0, c_write=1, c_valid_in=1, c_tag_in=req tag, c_data_block_in=refill block (line installed clean). Go COMPARE (replay, guaranteed hit).
- Index held constant from VICTIM through INSTALL so the array's chosen victim way is unchanged.
- cpu_req ignored outside IDLE; no second outstanding request.

## Timing
- Reset (rst=0 at edge): state IDLE, all latches, counters, outputs zero; overrides every state, including mid-WRITEBACK/REFILL (mem_req drops next cycle; memory side must tolerate an abandoned request, a late mem_ready is ignored in IDLE).
- cpu_ready, cpu_rdata and all c_*/mem_* outputs are decoded from state and latches; cpu_ready additionally gated combinationally by c_hit in COMPARE.
- Hit latency: accept at T, cpu_ready at T+1.
- Clean miss: COMPARE T+1, VICTIM T+2, REFILL from T+3 until mem_ready at cycle R, INSTALL R+1, COMPARE/cpu_ready R+2.
- Dirty miss adds WRITEBACK from T+3 to its mem_ready cycle W; REFILL starts W+1.
- mem_ready in same cycle mem_req first asserts is legal (zero wait).
- mem_ready outside WRITEBACK/REFILL ignored.
- Counters wrap 16'hFFFF -> 0.
- cpu_req held high after cpu_ready is taken as a new request in the following IDLE cycle.

## Test plan
- Reset: hold rst=0 3 cycles with cpu_req=1 -> cpu_ready=0, mem_req=0, c_enable=0, miss_cnt=wb_cnt=0.
- Cold load 0x0000_1040, memory returns block with word 0 = 0xDEADBEEF, mem_ready 4 cycles after mem_req -> one REFILL mem_addr=0x0000_1040, mem_we never 1, cpu_rdata=0xDEADBEEF, miss_cnt=1, total latency 9 cycles.
- Repeat load 0x0000_1044 -> hit, cpu_ready at T+1, no mem_req.
- Store 0x0000_1040 byte_w_en=4'b0011 data 0x0000_1234, then load -> 0xDEAD1234.
- Fill both ways of index 2 with tags A,B, dirty one, access third tag C mapping to index 2 -> WRITEBACK precedes REFILL when dirty victim chosen, mem_wdata equals victim block, wb_cnt increments once.
- Assert rst=0 during REFILL wait, then release -> IDLE, mem_req=0 next cycle, late mem_ready ignored, next load proceeds normally.
